imem_dual_port: RTL
===================

// Module: imem_dual_port
// PURPOSE
//  Dual-read-port synchronous instruction memory. It answers the fetch stage's
//  imem_ren/imem_addr0/imem_addr1 requests with imem_rdata0/1 one cycle later.
//  A valid/ready load port writes one word per cycle to program it.
//  After reset an internal FSM fills every word with NOP_WORD before declaring mem_ready.
// PARAMETERS
//  ADDR_WIDTH   32             byte-address width (core_pkg::XLEN)
//  INSTR_WIDTH  32             instruction word width (core_pkg::XLEN)
//  DEPTH_WORDS  256            number of words; power of two, >=2
//  NOP_WORD     32'h00000013   clear-fill value; returned for invalid reads
// PORTS
//  clk          in   1            clock, all state on rising edge
//  reset        in   1            async reset, ACTIVE-LOW (asserted when 0)
//  imem_ren     in   1            read enable for both ports
//  imem_addr0   in   ADDR_WIDTH   port-0 byte address
//  imem_addr1   in   ADDR_WIDTH   port-1 byte address
//  imem_rdata0  out  INSTR_WIDTH  port-0 registered read data
//  imem_rdata1  out  INSTR_WIDTH  port-1 registered read data
//  imem_rvalid  out  1            rdata0/1 updated by a read issued last cycle
//  mem_ready    out  1            clear complete; memory contents defined
//  ld_valid     in   1            load request
//  ld_ready     out  1            load accepted when ld_valid&&ld_ready
//  ld_addr      in   ADDR_WIDTH   load byte address
//  ld_data      in   INSTR_WIDTH  load word
//  imem_err     out  1            sticky: misaligned/out-of-range read or load seen
//  err_clr      in   1            synchronous clear of imem_err
// BEHAVIOUR
//  Reset (reset==0, async):
//  - rdata0/1=NOP_WORD; rvalid=0; mem_ready=0; ld_ready=0; imem_err=0.
//  - State=CLEAR, clr_cnt=0. The array itself is not reset.
//  Index and validity:
//  - idx = addr[$clog2(DEPTH_WORDS)+1:2].
//  - An access is valid iff addr[1:0]==0 and addr>>2 < DEPTH_WORDS.
//  FSM:
//  - CLEAR: each cycle writes NOP_WORD to mem[clr_cnt]; clr_cnt++.
//    On clr_cnt==DEPTH_WORDS-1 the write occurs and next state=RUN.
//  - RUN: mem_ready=1 and ld_ready=1, both registered.
//    They rise the cycle after the last clear write, exactly DEPTH_WORDS cycles after reset release.
//  - CLEAR->RUN only. Reset in any state returns to CLEAR with clr_cnt=0, which restarts the fill.
//  Read (RUN or CLEAR), 1-cycle latency:
//  - If imem_ren at edge N, rdata0/1 and rvalid=1 are updated at edge N+1.
//  - If !imem_ren, rdata0/1 hold their previous value and rvalid=0 next cycle.
//  - In CLEAR, or for an invalid address on a port, that port returns NOP_WORD.
//  - An invalid address in RUN sets imem_err. Each port is judged independently.
//  - Both ports at the same address return identical data.
//  Load (RUN only):
//  - On ld_valid&&ld_ready, mem[idx(ld_addr)] <= ld_data if ld_addr is valid.
//  - If ld_addr is invalid, the write is dropped, imem_err is set, and the handshake still completes.
//  - ld_ready is 0 in CLEAR, so loads stall. There is no backpressure in RUN.
//  Collision:
//  - A read and a load to the same idx in the same cycle is read-first.
//  - The read returns the old word; the new word is visible to reads issued the next cycle.
//  imem_err:
//  - Set-dominant over err_clr in the same cycle.
//  - Held until err_clr with no new error.
// TESTING
//  T1 reset: drop reset mid-CLEAR (cycle 5) -> clr_cnt restarts.
//     mem_ready rises exactly DEPTH_WORDS cycles after reset release.
//     Reads issued during CLEAR return 32'h00000013.
//  T2 load+read: load 0x00<-11111111, 0x04<-22222222.
//     ren, addr0=0x00, addr1=0x04 -> next cycle rdata0=11111111, rdata1=22222222, rvalid=1.
//  T3 hold: ren=0 for 3 cycles after T2 -> rdata unchanged, rvalid=0.
//  T4 collision: mem[2]=33333333; same cycle load 0x08<-AAAAAAAA and read 0x08.
//     -> rdata0=33333333. Read next cycle -> AAAAAAAA.
//  T5 errors: read addr1=0x06 -> rdata1=NOP, imem_err=1.
//     Load addr DEPTH_WORDS*4 -> dropped, err stays 1.
//     err_clr -> 0. err_clr with a simultaneous bad read -> stays 1.
//  T6 stream: back-to-back ren with pairs 0x00/0x04, 0x08/0x0C, 0x10/0x14
//     -> matching data every cycle with 1-cycle lag, no bubbles.

Source files
------------

// File: rtl/imem_dual_port.sv
// Dual-read-port instruction memory with a valid/ready load port and a post-reset NOP fill.
// Latency: read data and rvalid are registered, one cycle after imem_ren; loads commit at the accepting edge.
// Backpressure: ld_ready is low while the fill runs and high afterwards, so loads never stall once running.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_ren, imem_addr0/1 -> imem_rdata0/1, imem_rvalid   fetch read pair (byte addresses)
//   ld_valid, ld_addr, ld_data -> ld_ready                 program-load write port
//   mem_ready                                              fill finished, contents defined
//   imem_err, err_clr                                      sticky bad-address flag and its clear
module imem_dual_port #(
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter int unsigned             DEPTH_WORDS = 256,
  parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = INSTR_WIDTH'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   imem_ren,
  input  logic [ADDR_WIDTH-1:0]  imem_addr0,
  input  logic [ADDR_WIDTH-1:0]  imem_addr1,
  output logic [INSTR_WIDTH-1:0] imem_rdata0,
  output logic [INSTR_WIDTH-1:0] imem_rdata1,
  output logic                   imem_rvalid,
  output logic                   mem_ready,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_WIDTH-1:0]  ld_addr,
  input  logic [INSTR_WIDTH-1:0] ld_data,
  output logic                   imem_err,
  input  logic                   err_clr
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic [INSTR_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [INSTR_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH_WORDS];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [INSTR_WIDTH-1:0] mem_wdata;

  logic                   run;
  logic                   ok0, ok1, ld_ok;
  logic [IDX_W-1:0]       idx0, idx1, ld_idx;
  logic                   ld_fire;
  logic                   err_set;

  // A word index only addresses the array when it is word-aligned and below DEPTH_WORDS;
  // the index slice alone would alias out-of-range addresses back into the array.
  assign idx0   = imem_addr0[IDX_W+1:2];
  assign idx1   = imem_addr1[IDX_W+1:2];
  assign ld_idx = ld_addr[IDX_W+1:2];
  assign ok0    = (imem_addr0[1:0] == 2'b00) && ((imem_addr0 >> 2) < ADDR_WIDTH'(DEPTH_WORDS));
  assign ok1    = (imem_addr1[1:0] == 2'b00) && ((imem_addr1 >> 2) < ADDR_WIDTH'(DEPTH_WORDS));
  assign ld_ok  = (ld_addr[1:0] == 2'b00) && ((ld_addr >> 2) < ADDR_WIDTH'(DEPTH_WORDS));

  assign run     = (state_q == ST_RUN);
  assign ld_fire = ld_valid && run;

  // Fill sequencer and write-port mux: the fill owns the write port until it finishes.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = NOP_WORD;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ld_fire && ld_ok) begin
          mem_we    = 1'b1;
          mem_waddr = ld_idx;
          mem_wdata = ld_data;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Reads sample the array before this edge's write lands, giving read-first collisions.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rvalid_d = imem_ren;
    if (imem_ren) begin
      rdata0_d = (run && ok0) ? mem[idx0] : NOP_WORD;
      rdata1_d = (run && ok1) ? mem[idx1] : NOP_WORD;
    end
  end

  // New errors win over a same-cycle clear.
  always_comb begin
    err_set = run && ((imem_ren && (!ok0 || !ok1)) || (ld_fire && !ld_ok));
    err_d   = err_set || (err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rdata0_q  <= NOP_WORD;
      rdata1_q  <= NOP_WORD;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // Storage is deliberately left out of reset; the fill defines it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign imem_rdata0 = rdata0_q;
  assign imem_rdata1 = rdata1_q;
  assign imem_rvalid = rvalid_q;
  assign mem_ready   = run;
  assign ld_ready    = run;
  assign imem_err    = err_q;

endmodule
